// File: rtl/ct_idu_rf_vsrc_oper_reg_if.sv
// ---------------------------------------------------------------------------
// ct_idu_rf_vsrc_oper_reg_if
// Bundles the RF-stage vector operand signals between the RF issue side and
// the EX1 operand register.
//   master : RF issue / forwarding side (drives RF inputs, observes outputs)
//   slave  : ct_idu_rf_vsrc_oper_reg
// Signals:
//   rtu_yy_xx_flush            pipeline flush
//   rf_inst_vld                RF instruction valid
//   rf_srcv_vld[NSRC]          per-source used flags
//   rf_srcv_fwd_data[NSRC*DW]  per-source forward mux data
//   rf_srcv_no_fwd[NSRC]       per-source no-forward-hit flags
//   vrf_srcv_rdata[NSRC*DW]    VRF read data
//   vfpu_ex1_stall             EX1 back-pressure
//   rf_launch                  RF instruction moves to EX1 this cycle
//   rf_srcv_hold_vld[NSRC]     per-source captured-forward flags
//   ex1_inst_vld               EX1 valid
//   ex1_srcv_data[NSRC*DW]     EX1 operands
// ---------------------------------------------------------------------------
interface ct_idu_rf_vsrc_oper_reg_if #(
    parameter int unsigned NSRC = 3,
    parameter int unsigned DW   = 64
);
    logic                 rtu_yy_xx_flush;
    logic                 rf_inst_vld;
    logic [NSRC-1:0]      rf_srcv_vld;
    logic [NSRC*DW-1:0]   rf_srcv_fwd_data;
    logic [NSRC-1:0]      rf_srcv_no_fwd;
    logic [NSRC*DW-1:0]   vrf_srcv_rdata;
    logic                 vfpu_ex1_stall;
    logic                 rf_launch;
    logic [NSRC-1:0]      rf_srcv_hold_vld;
    logic                 ex1_inst_vld;
    logic [NSRC*DW-1:0]   ex1_srcv_data;

    modport master (
        output rtu_yy_xx_flush, rf_inst_vld, rf_srcv_vld, rf_srcv_fwd_data,
               rf_srcv_no_fwd, vrf_srcv_rdata, vfpu_ex1_stall,
        input  rf_launch, rf_srcv_hold_vld, ex1_inst_vld, ex1_srcv_data
    );

    modport slave (
        input  rtu_yy_xx_flush, rf_inst_vld, rf_srcv_vld, rf_srcv_fwd_data,
               rf_srcv_no_fwd, vrf_srcv_rdata, vfpu_ex1_stall,
        output rf_launch, rf_srcv_hold_vld, ex1_inst_vld, ex1_srcv_data
    );
endinterface

// File: rtl/ct_idu_rf_vsrc_oper_reg.sv
// ---------------------------------------------------------------------------
// ct_idu_rf_vsrc_oper_reg
// RF-stage vector operand register. Per source selects held-forward >
// live-forward > VRF read data and registers it into the EX1 operand flops.
// Forward data is only valid in the producer's match cycle, so a forward hit
// seen while EX1 stalls RF is captured and held until launch.
// Ports:
//   forever_cpuclk  clock
//   cpurst_b        asynchronous reset, active-low
//   bus             ct_idu_rf_vsrc_oper_reg_if.slave (RF inputs, EX1 outputs)
// ---------------------------------------------------------------------------
module ct_idu_rf_vsrc_oper_reg #(
    parameter int unsigned NSRC = 3,
    parameter int unsigned DW   = 64
) (
    input  logic                          forever_cpuclk,
    input  logic                          cpurst_b,
    ct_idu_rf_vsrc_oper_reg_if.slave      bus
);

    localparam int unsigned BUS_W = NSRC * DW;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_HELD  = 1'b1
    } hold_state_e;

    hold_state_e         hold_state_q [NSRC];
    hold_state_e         hold_state_d [NSRC];
    logic [DW-1:0]       hold_data_q  [NSRC];
    logic [DW-1:0]       hold_data_d  [NSRC];
    logic                ex1_inst_vld_q;
    logic                ex1_inst_vld_d;
    logic [BUS_W-1:0]    ex1_srcv_data_q;
    logic [BUS_W-1:0]    ex1_srcv_data_d;

    logic                launch_c;
    logic [BUS_W-1:0]    oper_sel_c;
    logic [NSRC-1:0]     hold_vld_c;

    // RF moves to EX1 when valid, not back-pressured and not flushed
    assign launch_c = bus.rf_inst_vld & ~bus.vfpu_ex1_stall & ~bus.rtu_yy_xx_flush;

    // Per-source operand priority: held forward > live forward > VRF
    always_comb begin
        oper_sel_c = '0;
        hold_vld_c = '0;
        for (int n = 0; n < int'(NSRC); n++) begin
            hold_vld_c[n] = (hold_state_q[n] == HOLD_HELD);
            if (hold_state_q[n] == HOLD_HELD) begin
                oper_sel_c[n*DW +: DW] = hold_data_q[n];
            end else if (!bus.rf_srcv_no_fwd[n]) begin
                oper_sel_c[n*DW +: DW] = bus.rf_srcv_fwd_data[n*DW +: DW];
            end else begin
                oper_sel_c[n*DW +: DW] = bus.vrf_srcv_rdata[n*DW +: DW];
            end
        end
    end

    // Next state: per-source hold FSM and EX1 operand register
    always_comb begin
        for (int n = 0; n < int'(NSRC); n++) begin
            hold_state_d[n] = hold_state_q[n];
            hold_data_d[n]  = hold_data_q[n];
        end
        ex1_inst_vld_d  = ex1_inst_vld_q;
        ex1_srcv_data_d = ex1_srcv_data_q;

        for (int n = 0; n < int'(NSRC); n++) begin
            case (hold_state_q[n])
                HOLD_EMPTY: begin
                    // Launch needs !stall, so capture and launch are exclusive
                    if (bus.rf_inst_vld && bus.vfpu_ex1_stall && bus.rf_srcv_vld[n] &&
                        !bus.rf_srcv_no_fwd[n] && !bus.rtu_yy_xx_flush) begin
                        hold_state_d[n] = HOLD_HELD;
                        hold_data_d[n]  = bus.rf_srcv_fwd_data[n*DW +: DW];
                    end
                end
                HOLD_HELD: begin
                    // Later forward hits are the same preg/value: never overwrite
                    if (bus.rtu_yy_xx_flush || launch_c || !bus.rf_inst_vld) begin
                        hold_state_d[n] = HOLD_EMPTY;
                    end
                end
                default: hold_state_d[n] = HOLD_EMPTY;
            endcase
        end

        if (bus.rtu_yy_xx_flush) begin
            ex1_inst_vld_d = 1'b0;
        end else if (launch_c) begin
            ex1_inst_vld_d = 1'b1;
            // Unused sources keep their previous EX1 contents
            for (int n = 0; n < int'(NSRC); n++) begin
                if (bus.rf_srcv_vld[n]) begin
                    ex1_srcv_data_d[n*DW +: DW] = oper_sel_c[n*DW +: DW];
                end
            end
        end else if (!bus.vfpu_ex1_stall) begin
            ex1_inst_vld_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int n = 0; n < int'(NSRC); n++) begin
                hold_state_q[n] <= HOLD_EMPTY;
                hold_data_q[n]  <= '0;
            end
            ex1_inst_vld_q  <= 1'b0;
            ex1_srcv_data_q <= '0;
        end else begin
            for (int n = 0; n < int'(NSRC); n++) begin
                hold_state_q[n] <= hold_state_d[n];
                hold_data_q[n]  <= hold_data_d[n];
            end
            ex1_inst_vld_q  <= ex1_inst_vld_d;
            ex1_srcv_data_q <= ex1_srcv_data_d;
        end
    end

    assign bus.rf_launch        = launch_c;
    assign bus.rf_srcv_hold_vld = hold_vld_c;
    assign bus.ex1_inst_vld     = ex1_inst_vld_q;
    assign bus.ex1_srcv_data    = ex1_srcv_data_q;

endmodule

// File: tb/tb_ct_idu_rf_vsrc_oper_reg.sv
// ---------------------------------------------------------------------------
// tb_ct_idu_rf_vsrc_oper_reg
// Directed scenarios plus randomized traffic checked against a cycle-level
// behavioural model of the RF operand register.
// ---------------------------------------------------------------------------
module tb_ct_idu_rf_vsrc_oper_reg;

    localparam int unsigned NSRC  = 3;
    localparam int unsigned DW    = 64;
    localparam int unsigned BUS_W = NSRC * DW;

    logic clk;
    logic rst_n;

    ct_idu_rf_vsrc_oper_reg_if #(.NSRC(NSRC), .DW(DW)) bus_if ();

    ct_idu_rf_vsrc_oper_reg #(.NSRC(NSRC), .DW(DW)) dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .bus            (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [NSRC-1:0]  m_held;
    logic [DW-1:0]    m_hdata [NSRC];
    logic             m_ex1_vld;
    logic [BUS_W-1:0] m_ex1_data;

    task automatic check(input string tag, input logic [BUS_W-1:0] got,
                         input logic [BUS_W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] sl(input logic [BUS_W-1:0] v, input int n);
        return v[n*DW +: DW];
    endfunction

    task automatic model_reset();
        m_held     = '0;
        m_ex1_vld  = 1'b0;
        m_ex1_data = '0;
        for (int n = 0; n < int'(NSRC); n++) m_hdata[n] = '0;
    endtask

    // One RF cycle: apply inputs, check launch, advance model and DUT, check state
    task automatic cycle(input logic inst, input logic stall, input logic flush,
                         input logic [NSRC-1:0] used, input logic [NSRC-1:0] nofwd,
                         input logic [BUS_W-1:0] fwd, input logic [BUS_W-1:0] vrf);
        logic            launch;
        logic [DW-1:0]   oper [NSRC];
        bus_if.rf_inst_vld      = inst;
        bus_if.vfpu_ex1_stall   = stall;
        bus_if.rtu_yy_xx_flush  = flush;
        bus_if.rf_srcv_vld      = used;
        bus_if.rf_srcv_no_fwd   = nofwd;
        bus_if.rf_srcv_fwd_data = fwd;
        bus_if.vrf_srcv_rdata   = vrf;
        #1;
        launch = inst && !stall && !flush;
        check("rf_launch", BUS_W'(bus_if.rf_launch), BUS_W'(launch));

        for (int n = 0; n < int'(NSRC); n++)
            oper[n] = m_held[n] ? m_hdata[n] : (!nofwd[n] ? sl(fwd, n) : sl(vrf, n));

        if (flush) begin
            m_held    = '0;
            m_ex1_vld = 1'b0;
        end else if (launch) begin
            m_held    = '0;
            m_ex1_vld = 1'b1;
            for (int n = 0; n < int'(NSRC); n++)
                if (used[n]) m_ex1_data[n*DW +: DW] = oper[n];
        end else if (!inst) begin
            m_held = '0;
            if (!stall) m_ex1_vld = 1'b0;
        end else begin
            // valid instruction stalled: grab first forward hit per used source
            for (int n = 0; n < int'(NSRC); n++) begin
                if (!m_held[n] && used[n] && !nofwd[n]) begin
                    m_held[n]  = 1'b1;
                    m_hdata[n] = sl(fwd, n);
                end
            end
        end

        @(posedge clk);
        #1;
        check("hold_vld", BUS_W'(bus_if.rf_srcv_hold_vld), BUS_W'(m_held));
        check("ex1_vld",  BUS_W'(bus_if.ex1_inst_vld),     BUS_W'(m_ex1_vld));
        check("ex1_data", bus_if.ex1_srcv_data,            m_ex1_data);
    endtask

    function automatic logic [BUS_W-1:0] put(input logic [DW-1:0] d0,
                                             input logic [DW-1:0] d1,
                                             input logic [DW-1:0] d2);
        return {d2, d1, d0};
    endfunction

    function automatic logic [DW-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        logic [BUS_W-1:0] prev;
        rst_n = 1'b0;
        bus_if.rf_inst_vld      = 1'b0;
        bus_if.vfpu_ex1_stall   = 1'b0;
        bus_if.rtu_yy_xx_flush  = 1'b0;
        bus_if.rf_srcv_vld      = '0;
        bus_if.rf_srcv_no_fwd   = '1;
        bus_if.rf_srcv_fwd_data = '0;
        bus_if.vrf_srcv_rdata   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ex1_vld",  BUS_W'(bus_if.ex1_inst_vld),     '0);
        check("rst_hold_vld", BUS_W'(bus_if.rf_srcv_hold_vld), '0);
        check("rst_ex1_data", bus_if.ex1_srcv_data,            '0);
        rst_n = 1'b1;

        // No stall: src0 forwarded, src1 from VRF
        cycle(1, 0, 0, 3'b011, 3'b110, put({16{4'hA}}, 64'h0, 64'h0),
              put(64'h0, 64'h1234, 64'h0));
        check("t2_vld",  BUS_W'(bus_if.ex1_inst_vld), BUS_W'(1'b1));
        check("t2_src0", BUS_W'(sl(bus_if.ex1_srcv_data, 0)), BUS_W'({16{4'hA}}));
        check("t2_src1", BUS_W'(sl(bus_if.ex1_srcv_data, 1)), BUS_W'(64'h1234));

        // Stall 3 cycles, forward on src2 only in the first
        cycle(1, 1, 0, 3'b100, 3'b011, put(64'h0, 64'h0, 64'hDEAD), '0);
        check("t3_hold_c1", BUS_W'(bus_if.rf_srcv_hold_vld), BUS_W'(3'b100));
        cycle(1, 1, 0, 3'b100, 3'b111, '0, '0);
        cycle(1, 1, 0, 3'b100, 3'b111, '0, '0);
        check("t3_hold_c3", BUS_W'(bus_if.rf_srcv_hold_vld), BUS_W'(3'b100));
        cycle(1, 0, 0, 3'b100, 3'b111, '0, '0);
        check("t3_src2", BUS_W'(sl(bus_if.ex1_srcv_data, 2)), BUS_W'(64'hDEAD));
        check("t3_hold_clr", BUS_W'(bus_if.rf_srcv_hold_vld), '0);

        // Second forward hit on a held source is ignored
        cycle(1, 1, 0, 3'b100, 3'b011, put(64'h0, 64'h0, 64'hDEAD), '0);
        cycle(1, 1, 0, 3'b100, 3'b011, put(64'h0, 64'h0, 64'hBEEF), '0);
        cycle(1, 0, 0, 3'b100, 3'b011, put(64'h0, 64'h0, 64'hBEEF), '0);
        check("t4_src2", BUS_W'(sl(bus_if.ex1_srcv_data, 2)), BUS_W'(64'hDEAD));

        // Flush while all three sources are held
        cycle(1, 1, 0, 3'b111, 3'b000, put(64'h11, 64'h22, 64'h33), '0);
        check("t5_hold", BUS_W'(bus_if.rf_srcv_hold_vld), BUS_W'(3'b111));
        cycle(1, 1, 1, 3'b111, 3'b000, put(64'h44, 64'h55, 64'h66), '0);
        check("t5_hold_clr", BUS_W'(bus_if.rf_srcv_hold_vld), '0);
        check("t5_ex1_vld",  BUS_W'(bus_if.ex1_inst_vld),     '0);

        // Partial source write
        cycle(1, 0, 0, 3'b111, 3'b111, '0, put(64'hA0, 64'hA1, 64'hA2));
        prev = bus_if.ex1_srcv_data;
        cycle(1, 0, 0, 3'b010, 3'b000, put(64'hB0, 64'hB1, 64'hB2),
              put(64'hC0, 64'hC1, 64'hC2));
        check("t6_src0", BUS_W'(sl(bus_if.ex1_srcv_data, 0)), BUS_W'(sl(prev, 0)));
        check("t6_src1", BUS_W'(sl(bus_if.ex1_srcv_data, 1)), BUS_W'(64'hB1));
        check("t6_src2", BUS_W'(sl(bus_if.ex1_srcv_data, 2)), BUS_W'(sl(prev, 2)));

        // Reset asserted mid-stall
        cycle(1, 1, 0, 3'b111, 3'b000, put(64'h7, 64'h8, 64'h9), '0);
        rst_n = 1'b0;
        #1;
        check("t1_ex1_vld",  BUS_W'(bus_if.ex1_inst_vld),     '0);
        check("t1_hold_vld", BUS_W'(bus_if.rf_srcv_hold_vld), '0);
        check("t1_ex1_data", bus_if.ex1_srcv_data,            '0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 19) == 0), 3'($urandom()), 3'($urandom()),
                  put(rnd64(), rnd64(), rnd64()), put(rnd64(), rnd64(), rnd64()));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
